// File: rtl/sub4_sched.sv
// sub4_sched: walks the 5x5 grid of 2x2 pooling windows over the C3 feature
// map, streams the 64 pixels of each window (sub-sample major, channel minor)
// to the pooling bank and waits for the pooled vector before moving on.
module sub4_sched #(
  parameter int FM_W     = 10,
  parameter int OUT_CH   = 16,
  parameter int OUT_BITS = 16,
  parameter int ADDR_W   = 11
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       win_ready,
  output logic                       fm_rd_en,
  output logic [ADDR_W-1:0]          fm_rd_addr,
  input  logic signed [OUT_BITS-1:0] fm_rd_data,
  output logic                       c3_valid,
  output logic [15:0]                c3_ch,
  output logic signed [OUT_BITS-1:0] c3_pix,
  input  logic                       s4_valid_in,
  output logic [4:0]                 s4_addr,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int PW    = FM_W / 2;
  localparam int PR_W  = $clog2(PW);
  localparam int CH_W  = $clog2(OUT_CH);
  localparam int PLANE = FM_W * FM_W;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_FIN} state_t;

  state_t          state_q, state_d;
  logic [PR_W-1:0] pr_q, pr_d, pc_q, pc_d;
  logic [1:0]      ss_q, ss_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [4:0]      s4_q, s4_d;
  logic            err_q, err_d;
  logic            c3_vld_q;
  logic [CH_W-1:0] c3_ch_q;
  logic            last_win;

  assign last_win = (pr_q == PR_W'(PW - 1)) && (pc_q == PR_W'(PW - 1));

  // State, window/sub-sample/channel counters and the aligned beat registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pr_q     <= '0;
      pc_q     <= '0;
      ss_q     <= '0;
      ch_q     <= '0;
      s4_q     <= '0;
      err_q    <= 1'b0;
      c3_vld_q <= 1'b0;
      c3_ch_q  <= '0;
    end else begin
      state_q  <= state_d;
      pr_q     <= pr_d;
      pc_q     <= pc_d;
      ss_q     <= ss_d;
      ch_q     <= ch_d;
      s4_q     <= s4_d;
      err_q    <= err_d;
      c3_vld_q <= fm_rd_en;
      c3_ch_q  <= ch_q;
    end
  end

  // Next-state logic: issue a full window without pausing, then wait for the pooled vector
  always_comb begin
    logic err_clr;
    state_d = state_q;
    pr_d    = pr_q;
    pc_d    = pc_q;
    ss_d    = ss_q;
    ch_d    = ch_q;
    s4_d    = s4_q;
    err_clr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CHECK;
          pr_d    = '0;
          pc_d    = '0;
          ss_d    = '0;
          ch_d    = '0;
          s4_d    = '0;
          err_clr = 1'b1;
        end
      end
      S_CHECK: begin
        if (win_ready) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (ch_q == CH_W'(OUT_CH - 1)) begin
          ch_d = '0;
          ss_d = ss_q + 2'd1;
          if (ss_q == 2'd3) state_d = S_WAIT;
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end
      S_WAIT: begin
        if (s4_valid_in) begin
          s4_d = s4_q + 5'd1;
          if (last_win) begin
            pr_d    = '0;
            pc_d    = '0;
            state_d = S_FIN;
          end else begin
            state_d = S_CHECK;
            if (pc_q == PR_W'(PW - 1)) begin
              pc_d = '0;
              pr_d = pr_q + PR_W'(1);
            end else begin
              pc_d = pc_q + PR_W'(1);
            end
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A pooled vector arriving when none is awaited is a protocol error
    err_d = (err_clr ? 1'b0 : err_q) | (s4_valid_in && (state_q != S_WAIT));
  end

  // Outputs decoded from state; address is row = 2pr+ss[1], col = 2pc+ss[0]
  always_comb begin
    fm_rd_en   = (state_q == S_ISSUE);
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_FIN);
    fm_rd_addr = ADDR_W'(ch_q) * ADDR_W'(PLANE)
               + ADDR_W'({pr_q, ss_q[1]}) * ADDR_W'(FM_W)
               + ADDR_W'({pc_q, ss_q[0]});
  end

  assign c3_valid = c3_vld_q;
  assign c3_ch    = 16'(c3_ch_q);
  assign c3_pix   = fm_rd_data;
  assign s4_addr  = s4_q;
  assign err      = err_q;

endmodule

// File: doc/sub4_sched.md
SUB4_SCHED -- requirements
Module: sub4_sched

Interface
REQ-001 Parameters: FM_W 10 (C3 map width/height); OUT_CH 16 (channels); OUT_BITS 16 (pixel width); ADDR_W 11 (feature-map RAM address width).
REQ-002 Reset is rst_n, synchronous, active-low; clock is clk.
REQ-003 Port clk, input, 1, rising-edge clock.
REQ-004 Port rst_n, input, 1, synchronous active-low reset.
REQ-005 Port start, input, 1, single-cycle frame start request.
REQ-006 Port win_ready, input, 1, downstream can accept the next pooled vector.
REQ-007 Port fm_rd_en, output, 1, C3 RAM read strobe.
REQ-008 Port fm_rd_addr, output, ADDR_W, C3 RAM address = ch*FM_W*FM_W + row*FM_W + col.
REQ-009 Port fm_rd_data, input, OUT_BITS signed, RAM data, valid 1 cycle after fm_rd_en.
REQ-010 Port c3_valid, output, 1, beat valid to the pooling bank.
REQ-011 Port c3_ch, output, 16, channel index of the beat (0..15).
REQ-012 Port c3_pix, output, OUT_BITS signed, pixel (fm_rd_data passed through).
REQ-013 Port s4_valid_in, input, 1, pooled-vector valid returned from the pooling bank.
REQ-014 Port s4_addr, output, 5, pooled position index 0..24, valid while s4_valid_in is high.
REQ-015 Port busy, output, 1, frame in progress.
REQ-016 Port done, output, 1, one-cycle frame-complete pulse.
REQ-017 Port err, output, 1, sticky protocol error flag.

Function
REQ-018 FSM states: IDLE, CHECK, ISSUE, WAIT, FIN.
REQ-019 IDLE: on start=1, clear the window index (pr,pc), err, and s4_addr counter, then go to CHECK; start in any other state is ignored.
REQ-020 CHECK: stay until win_ready=1, then go to ISSUE; no read is issued in CHECK.
REQ-021 ISSUE: issue 64 reads on consecutive cycles with fm_rd_en=1, in ss-major order: ss 0..3 outer, ch 0..15 inner.
REQ-022 ISSUE pixel per ss: ss0=(2pr,2pc), ss1=(2pr,2pc+1), ss2=(2pr+1,2pc), ss3=(2pr+1,2pc+1), as (row,col).
REQ-023 ISSUE never pauses mid-window, so that the bank's internal ss counter stays aligned; win_ready is sampled only in CHECK.
REQ-024 c3_valid and c3_ch are the registered fm_rd_en and channel, delayed 1 cycle so they align with fm_rd_data; c3_pix = fm_rd_data.
REQ-025 After the 64th read, go to WAIT. Nominal timing: last read at T, last beat at T+1, s4_valid_in at T+2.
REQ-026 WAIT: on s4_valid_in=1, increment s4_addr and advance the window (pc 0..4 inner, pr 0..4 outer); go to CHECK, or to FIN after window 24.
REQ-027 FIN: done=1 for exactly one cycle, busy=0 from the following cycle, then return to IDLE.
REQ-028 s4_addr = pr*5+pc of the window currently awaited, so it is valid during s4_valid_in.
REQ-029 s4_valid_in outside WAIT sets err; err holds until the next accepted start or reset.
REQ-030 busy=1 in CHECK, ISSUE, WAIT and FIN.
REQ-031 fm_rd_addr is arithmetic-exact, with a maximum of 1599 for the default parameters, and has no wrap-around.
REQ-032 A frame takes 25 windows × (64+3) cycles plus stall cycles, from start to done.

Reset
REQ-033 While rst_n=0 at a clock edge: state=IDLE; fm_rd_en, c3_valid, busy, done, err = 0; c3_ch, fm_rd_addr, s4_addr, pr, pc, ss, ch = 0.
REQ-034 Reset mid-frame aborts immediately with no further beats emitted; the pooling bank shares rst_n, so its ss alignment is restored.

Verification
REQ-035 Reset: assert rst_n=0 mid-ISSUE -> next cycle all outputs 0 and state IDLE; no c3_valid until a new start.
REQ-036 Full frame: RAM word = address, win_ready=1 -> 25 pooled vectors; channel ch of window (pr,pc) = ch*100+(2pr+1)*10+2pc+1 (window 0 ch3 = 311, window 24 ch15 = 1599); done exactly 1675 cycles after start.
REQ-037 Order check: window 7 (pr=1,pc=2) -> first four addresses 24, 124, 224, 324; beat 16 address = 25; beat 63 address = 1535.
REQ-038 Stall: win_ready=0 for 10 cycles after window 3 -> no fm_rd_en during the stall; s4_addr sequence stays contiguous 0..24; done delayed by 10 cycles.
REQ-039 Start during busy: pulse start in window 5 -> no restart, frame completes normally, single done pulse.
REQ-040 Spurious return: s4_valid_in=1 during ISSUE -> err=1 and held; next start clears err to 0.
